// File: rtl/hilo_md_sequencer.sv
// HI/LO multiply/divide sequencer: registered-operand multiplier and 32-step restoring divider.
// Optional MD_DIV_ZERO_FAST_EN: divide-by-zero skips the divider and completes one cycle after start.
module hilo_md_sequencer #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITER - 1);

    state_t      r_state;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_bmag;
    logic        r_sa;
    logic        r_sb;

    logic        w_accept;
    logic        w_in_sa;
    logic        w_in_sb;
    logic [31:0] w_in_amag;
    logic [31:0] w_in_bmag;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [32:0] w_rem_sh;
    logic [32:0] w_rem_sub;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quot_nx;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    // Valid/ready: start is the request; stall acts as "not ready" back to the pipeline,
    // and hilo_we is the single-cycle completion strobe (suppressed by flush in that cycle).
    assign w_accept  = (r_state == S_IDLE) && start && !flush;
    assign stall     = w_accept || (r_state == S_MUL) || (r_state == S_DIV);
    assign busy      = (r_state != S_IDLE);
    assign hilo_we   = (r_state == S_DONE) && !flush;
    assign dbg_state = r_state;

    // Signed operand magnitudes; 0x80000000 maps to itself, which is correct as unsigned.
    assign w_in_sa   = !op[0] && src_a[31];
    assign w_in_sb   = !op[0] && src_b[31];
    assign w_in_amag = w_in_sa ? -src_a : src_a;
    assign w_in_bmag = w_in_sb ? -src_b : src_b;

    // Low 64 bits of a 64x64 product equal the signed product of sign-extended 32-bit operands.
    assign w_ext_a = {{32{!r_op[0] && r_a[31]}}, r_a};
    assign w_ext_b = {{32{!r_op[0] && r_b[31]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // One restoring step; the shifted remainder needs 33 bits before the compare.
    assign w_rem_sh  = {r_rem, r_quot[31]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_bmag};
    assign w_ge      = (w_rem_sh >= {1'b0, r_bmag});
    assign w_rem_nx  = w_ge ? w_rem_sub[31:0] : w_rem_sh[31:0];
    assign w_quot_nx = {r_quot[30:0], w_ge};
    assign w_q_fix   = (r_sa ^ r_sb) ? -w_quot_nx : w_quot_nx;
    assign w_r_fix   = r_sa ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_cnt   <= 6'd0;
            r_rem   <= 32'd0;
            r_quot  <= 32'd0;
            r_bmag  <= 32'd0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            hi_out  <= 32'd0;
            lo_out  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_a     <= src_a;
                        r_b     <= src_b;
                        r_cnt   <= 6'd0;
                        r_sa    <= w_in_sa;
                        r_sb    <= w_in_sb;
                        r_bmag  <= w_in_bmag;
                        r_rem   <= 32'd0;
                        r_quot  <= w_in_amag;
                        r_state <= op[1] ? S_DIV : S_MUL;
`ifdef MD_DIV_ZERO_FAST_EN
                        if (op[1] && (src_b == 32'd0)) begin
                            hi_out  <= src_a;
                            lo_out  <= w_in_sa ? 32'h0000_0001 : 32'hFFFF_FFFF;
                            r_state <= S_DONE;
                        end
`endif
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == MUL_LAST) begin
                        hi_out  <= w_prod[63:32];
                        lo_out  <= w_prod[31:0];
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem  <= w_rem_nx;
                        r_quot <= w_quot_nx;
                        r_cnt  <= r_cnt + 6'd1;
                        if (r_cnt == DIV_LAST) begin
                            hi_out  <= w_r_fix;
                            lo_out  <= w_q_fix;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_sequencer.sv
// Directed bench for hilo_md_sequencer: vector table run back-to-back plus flush and reset sequences.
module tb_hilo_md_sequencer;

`ifdef MD_DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 33;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_pass;
    vec_t vecs[10];

    hilo_md_sequencer #(.MUL_LAT(2), .DIV_ITER(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .stall(stall), .busy(busy), .hilo_we(hilo_we),
        .hi_out(hi_out), .lo_out(lo_out), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Starts one operation in the current (IDLE) cycle and follows it to its strobe.
    task automatic run_op(input string name, input vec_t v);
        int lat;
        logic stall_bad;
        lat = 0;
        stall_bad = 1'b0;
        check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
        op = v.op; src_a = v.a; src_b = v.b; start = 1'b1; flush = 1'b0;
        #1;
        check({name, "_stall_c0"}, {31'd0, stall}, 32'd1);
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = 1'b0;
            #1;
            if (hilo_we === 1'b1) begin
                lat = c;
                break;
            end
            if (stall !== 1'b1) stall_bad = 1'b1;
        end
        check({name, "_latency"}, lat, v.lat);
        check({name, "_stall_run"}, {31'd0, stall_bad}, 32'd0);
        if (lat != 0) begin
            check({name, "_hi"}, hi_out, v.hi);
            check({name, "_lo"}, lo_out, v.lo);
            check({name, "_stall_done"}, {31'd0, stall}, 32'd0);
        end
    endtask

    initial begin
        logic saw_we;
        vec_t v;
        n_checks = 0;
        n_pass   = 0;

        vecs[0] = '{2'b11, 32'd100,        32'd7,          33,     32'h0000_0002, 32'h0000_000E};
        vecs[1] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          33,     32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  33,     32'h0000_0000, 32'h8000_0000};
        vecs[3] = '{2'b00, 32'hFFFF_FFFF,  32'd2,          3,      32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[4] = '{2'b01, 32'hFFFF_FFFF,  32'd2,          3,      32'h0000_0001, 32'hFFFF_FFFE};
        vecs[5] = '{2'b11, 32'd5,          32'd0,          DZ_LAT, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[6] = '{2'b10, 32'hFFFF_FFFB,  32'd0,          DZ_LAT, 32'hFFFF_FFFB, 32'h0000_0001};
        vecs[7] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  33,     32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{2'b00, 32'hFFFF_FFFD,  32'hFFFF_FFFB,  3,      32'h0000_0000, 32'h0000_000F};
        vecs[9] = '{2'b11, 32'hFFFF_FFFF,  32'h0001_0000,  33,     32'h0000_FFFF, 32'h0000_FFFF};

        resetn = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
        #12;
        check("rst_stall",   {31'd0, stall},   32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_hilo_we", {31'd0, hilo_we}, 32'd0);
        check("rst_hi",      hi_out,           32'd0);
        check("rst_lo",      lo_out,           32'd0);
        check("rst_state",   {30'd0, dbg_state}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // start together with flush in IDLE must be ignored
        op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
        #1;
        check("startflush_stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        #1;
        check("startflush_busy", {31'd0, busy}, 32'd0);

        // Vectors run back-to-back: each start lands in the cycle after the previous strobe.
        for (int i = 0; i < 10; i++) begin
            tick();
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        // Flush in cycle 10 of a DIVU, then MULTU 3x5 in cycle 11.
        tick();
        saw_we = 1'b0;
        op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (c == 5) begin
                #1;
                check("div_state", {30'd0, dbg_state}, 32'd2);
            end
            if (c == 10) flush = 1'b1;
            #1;
            if (hilo_we === 1'b1) saw_we = 1'b1;
        end
        tick();
        flush = 1'b0;
        #1;
        check("flush_busy_c11",  {31'd0, busy},     32'd0);
        check("flush_state_c11", {30'd0, dbg_state}, 32'd0);
        check("flush_no_we",     {31'd0, saw_we | hilo_we}, 32'd0);
        v = '{2'b01, 32'd3, 32'd5, 3, 32'd0, 32'd15};
        run_op("post_flush_multu", v);

        // Flush in DONE suppresses the strobe.
        tick();
        op = 2'b01; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        #1;
        check("done_flush_state", {30'd0, dbg_state}, 32'd3);
        check("done_flush_we",    {31'd0, hilo_we},   32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("done_flush_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset at cycle 20 of a DIV.
        tick();
        op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        check("arst_stall",   {31'd0, stall},   32'd0);
        check("arst_busy",    {31'd0, busy},    32'd0);
        check("arst_hilo_we", {31'd0, hilo_we}, 32'd0);
        check("arst_hi",      hi_out,           32'd0);
        check("arst_lo",      lo_out,           32'd0);
        tick();
        tick();
        resetn = 1'b1;
        saw_we = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (hilo_we === 1'b1 || busy === 1'b1) saw_we = 1'b1;
        end
        check("arst_no_we_after", {31'd0, saw_we}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
